gpo_pad_seq_ctrl: RTL and testbench

- Parametrised NCH-channel controller for the EG1d80V GPO pad family; sits between core logic and the pad instances.
- Holds per-channel pad configuration: drive strength, slew, CO, and output mode (off, push-pull, open-drain-low, open-drain-high).
- Each reconfiguration runs as a glitch-safe sequence: tri-state, settle, apply, re-enable.
- Gates high-drive settings on VBIAS status and forces affected channels to tri-state on VBIAS loss.

---
 rtl/gpo_pad_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_gpo_pad_seq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpo_pad_seq_ctrl.sv
// Sequenced configuration controller for a bank of EG1d80V GPO pads.
// Each reconfiguration tri-states the pad, waits, applies the new settings and re-enables it.
module gpo_pad_seq_ctrl #(
  parameter int NCH        = 8,
  parameter int SETTLE_CYC = 4,
  parameter int CHW        = 3
) (
  input  logic             CLK_I,
  input  logic             RSTN_I,
  input  logic             CFG_WE_I,
  input  logic [CHW-1:0]   CFG_CH_I,
  input  logic [7:0]       CFG_DATA_I,
  output logic             CFG_BUSY_O,
  output logic             CFG_ERR_O,
  input  logic [NCH-1:0]   DATA_I,
  input  logic             VBIAS_OK_I,
  output logic [NCH-1:0]   DO_O,
  output logic [4*NCH-1:0] DS_O,
  output logic [NCH-1:0]   SR_O,
  output logic [NCH-1:0]   CO_O,
  output logic [NCH-1:0]   OE_O,
  output logic [NCH-1:0]   ODP_O,
  output logic [NCH-1:0]   ODN_O,
  output logic [NCH-1:0]   VBIAS_FAULT_O
);

  localparam int CNTW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_APPLY,
    ST_ENABLE
  } state_t;

  state_t          state_reg, state_next;
  logic [CHW-1:0]  ch_reg, ch_next;
  logic [7:0]      data_reg, data_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic            err_reg, err_next;

  logic [CHW-1:0]  op_ch;
  logic [7:0]      op_data;
  logic            ch_valid;
  logic            accept;
  logic            sel_oe;
  logic            apply_en;
  logic            oe_clr;
  logic            oe_set;
  logic            fault_set;
  logic            fault_clr;
  logic [NCH-1:0]  sel_vec;
  logic [NCH-1:0]  oe_vec;

  assign ch_valid = ({1'b0, CFG_CH_I} < (CHW+1)'(NCH));
  assign accept   = (state_reg == ST_IDLE) && CFG_WE_I && ch_valid;

  // In IDLE the incoming write is the operand, so actions can take effect on the accepting edge.
  assign op_ch   = (state_reg == ST_IDLE) ? CFG_CH_I : ch_reg;
  assign op_data = (state_reg == ST_IDLE) ? CFG_DATA_I : data_reg;
  assign sel_oe  = |(sel_vec & oe_vec);

  assign CFG_BUSY_O = (state_reg != ST_IDLE);
  assign CFG_ERR_O  = err_reg;

  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) begin
      state_reg <= ST_IDLE;
      ch_reg    <= '0;
      data_reg  <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    err_next   = CFG_WE_I && !accept;
    apply_en   = 1'b0;
    oe_clr     = 1'b0;
    oe_set     = 1'b0;
    fault_set  = 1'b0;
    fault_clr  = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          ch_next   = CFG_CH_I;
          data_next = CFG_DATA_I;
          fault_clr = 1'b1;
          if (sel_oe) begin
            oe_clr     = 1'b1;
            cnt_next   = CNTW'(SETTLE_CYC - 1);
            state_next = ST_DRAIN;
          end else begin
            // Pad already tri-stated: nothing to drain, apply right away.
            apply_en   = 1'b1;
            state_next = ST_APPLY;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_reg == '0) begin
          apply_en   = 1'b1;
          state_next = ST_APPLY;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_APPLY: begin
        state_next = ST_ENABLE;
        if (data_reg[7:6] != 2'b00) begin
          if (data_reg[1:0] == 2'b00 || VBIAS_OK_I) begin
            oe_set = 1'b1;
          end else begin
            fault_set = 1'b1;
          end
        end
      end
      ST_ENABLE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [3:0] ds_reg;
    logic       sr_reg;
    logic       co_reg;
    logic       oe_reg;
    logic       odp_reg;
    logic       odn_reg;
    logic       fault_reg;
    logic       do_reg;
    logic       vbias_drop;

    assign sel_vec[gi] = (op_ch == CHW'(gi));
    // High-drive settings are only safe with a settled bias supply.
    assign vbias_drop  = !VBIAS_OK_I && oe_reg && (ds_reg[1:0] != 2'b00);

    always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
        ds_reg    <= '0;
        sr_reg    <= 1'b0;
        co_reg    <= 1'b0;
        oe_reg    <= 1'b0;
        odp_reg   <= 1'b0;
        odn_reg   <= 1'b0;
        fault_reg <= 1'b0;
        do_reg    <= 1'b0;
      end else begin
        do_reg <= DATA_I[gi];
        if (apply_en && sel_vec[gi]) begin
          ds_reg  <= op_data[3:0];
          sr_reg  <= op_data[4];
          co_reg  <= op_data[5];
          odp_reg <= (op_data[7:6] == 2'b10);
          odn_reg <= (op_data[7:6] == 2'b11);
        end
        if (oe_clr && sel_vec[gi]) begin
          oe_reg <= 1'b0;
        end else if (oe_set && sel_vec[gi]) begin
          oe_reg <= 1'b1;
        end else if (vbias_drop) begin
          oe_reg <= 1'b0;
        end
        // An accepted write is the only way to clear a latched fault.
        if (fault_clr && sel_vec[gi]) begin
          fault_reg <= 1'b0;
        end else if (fault_set && sel_vec[gi]) begin
          fault_reg <= 1'b1;
        end else if (vbias_drop) begin
          fault_reg <= 1'b1;
        end
      end
    end

    assign oe_vec[gi]          = oe_reg;
    assign DO_O[gi]            = do_reg;
    assign DS_O[4*gi +: 4]     = ds_reg;
    assign SR_O[gi]            = sr_reg;
    assign CO_O[gi]            = co_reg;
    assign OE_O[gi]            = oe_reg;
    assign ODP_O[gi]           = odp_reg;
    assign ODN_O[gi]           = odn_reg;
    assign VBIAS_FAULT_O[gi]   = fault_reg;
  end

endmodule

// File: tb/tb_gpo_pad_seq_ctrl.sv
// Bench for gpo_pad_seq_ctrl: directed scenarios plus random traffic checked
// against an event-timeline reference model.
module tb_gpo_pad_seq_ctrl;

  localparam int NCH    = 8;
  localparam int SETTLE = 4;
  localparam int CHW    = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             we;
  logic [CHW-1:0]   ch;
  logic [7:0]       data;
  logic [NCH-1:0]   din;
  logic             vbias;
  logic             busy;
  logic             err;
  logic [NCH-1:0]   do_o, sr_o, co_o, oe_o, odp_o, odn_o, fault_o;
  logic [4*NCH-1:0] ds_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-channel pad state plus scheduled edge numbers for the pending write.
  logic [3:0]     m_ds [NCH];
  logic [NCH-1:0] m_sr, m_co, m_oe, m_odp, m_odn, m_fault, m_do;
  logic           m_err;
  logic [7:0]     m_pdata;
  int             m_pch, m_apply, m_enable, m_last_busy;
  int             ecnt = 0;

  gpo_pad_seq_ctrl #(
    .NCH       (NCH),
    .SETTLE_CYC(SETTLE),
    .CHW       (CHW)
  ) dut (
    .CLK_I        (clk),
    .RSTN_I       (rstn),
    .CFG_WE_I     (we),
    .CFG_CH_I     (ch),
    .CFG_DATA_I   (data),
    .CFG_BUSY_O   (busy),
    .CFG_ERR_O    (err),
    .DATA_I       (din),
    .VBIAS_OK_I   (vbias),
    .DO_O         (do_o),
    .DS_O         (ds_o),
    .SR_O         (sr_o),
    .CO_O         (co_o),
    .OE_O         (oe_o),
    .ODP_O        (odp_o),
    .ODN_O        (odn_o),
    .VBIAS_FAULT_O(fault_o)
  );

  always #5 clk = ~clk;

  function automatic logic [4*NCH-1:0] m_ds_vec();
    logic [4*NCH-1:0] v;
    for (int k = 0; k < NCH; k++) v[4*k +: 4] = m_ds[k];
    return v;
  endfunction

  function automatic logic m_busy();
    return (ecnt <= m_last_busy);
  endfunction

  task automatic model_step();
    logic [NCH-1:0] oe_old;
    bit acc;
    int d;
    ecnt++;
    if (!rstn) begin
      for (int k = 0; k < NCH; k++) m_ds[k] = 4'h0;
      {m_sr, m_co, m_oe, m_odp, m_odn, m_fault, m_do} = '0;
      m_err = 1'b0; m_pdata = 8'h00; m_pch = 0;
      m_apply = -1; m_enable = -1; m_last_busy = -10;
      return;
    end
    oe_old = m_oe;
    m_do   = din;
    acc    = we && (int'(ch) < NCH) && (ecnt - 1 > m_last_busy);
    m_err  = we && !acc;
    for (int k = 0; k < NCH; k++)
      if (!vbias && oe_old[k] && m_ds[k][1:0] != 2'b00) begin
        m_oe[k] = 1'b0; m_fault[k] = 1'b1;
      end
    if (acc) begin
      m_pch   = int'(ch);
      m_pdata = data;
      d       = oe_old[m_pch] ? SETTLE : 0;
      m_oe[m_pch] = 1'b0; m_fault[m_pch] = 1'b0;
      m_apply = ecnt + d; m_enable = ecnt + d + 1; m_last_busy = ecnt + d + 1;
    end
    if (m_apply == ecnt) begin
      m_ds[m_pch]  = m_pdata[3:0];
      m_sr[m_pch]  = m_pdata[4];
      m_co[m_pch]  = m_pdata[5];
      m_odp[m_pch] = (m_pdata[7:6] == 2'd2);
      m_odn[m_pch] = (m_pdata[7:6] == 2'd3);
    end
    if (m_enable == ecnt && m_pdata[7:6] != 2'd0) begin
      if (m_pdata[1:0] == 2'd0 || vbias) m_oe[m_pch] = 1'b1;
      else m_fault[m_pch] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    din = NCH'($urandom);
  endtask

  task automatic write_cfg(input int c, input logic [7:0] d);
    we = 1'b1; ch = CHW'(c); data = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      we = 1'($urandom); ch = CHW'($urandom); data = 8'($urandom); vbias = 1'($urandom);
      tick();
      n_checks++;
      if ({do_o, ds_o, sr_o, co_o, oe_o, odp_o, odn_o, fault_o, err} !== '0) begin
        n_errors++; $display("FAIL reset_outputs: oe=%b ds=%h fault=%b err=%b, expected all 0", oe_o, ds_o, fault_o, err);
      end
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    end
    rstn = 1'b1; we = 1'b0; vbias = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_cold_enable();
    write_cfg(2, 8'h40);
    n_checks++;
    if (busy !== 1'b1 || oe_o !== 8'h00 || ds_o[11:8] !== 4'h0 || odp_o[2] !== 1'b0 || odn_o[2] !== 1'b0) begin
      n_errors++; $display("FAIL cold_apply: busy=%b oe=%b ds=%h, expected busy 1 oe 0 ds 0", busy, oe_o, ds_o[11:8]);
    end
    tick();
    n_checks++;
    if (oe_o !== 8'h04 || busy !== 1'b1) begin
      n_errors++; $display("FAIL cold_enable: oe=%b busy=%b, expected oe 00000100 busy 1", oe_o, busy);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || oe_o[2] !== 1'b1) begin
      n_errors++; $display("FAIL cold_idle: busy=%b oe2=%b, expected 0/1", busy, oe_o[2]);
    end
    $display("cold_enable: ch2 data 40 done");
  endtask

  task automatic test_live_reconfig();
    vbias = 1'b1;
    write_cfg(2, 8'h83);
    for (int i = 1; i <= SETTLE; i++) begin
      if (i > 1) tick();
      n_checks++;
      if (oe_o[2] !== 1'b0 || ds_o[11:8] !== 4'h0 || busy !== 1'b1) begin
        n_errors++; $display("FAIL live_drain t+%0d: oe2=%b ds=%h busy=%b, expected 0/0/1", i, oe_o[2], ds_o[11:8], busy);
      end
    end
    tick();
    n_checks++;
    if (ds_o[11:8] !== 4'h3 || odp_o[2] !== 1'b1 || odn_o[2] !== 1'b0 || oe_o[2] !== 1'b0) begin
      n_errors++; $display("FAIL live_apply: ds=%h odp=%b odn=%b oe=%b, expected 3/1/0/0", ds_o[11:8], odp_o[2], odn_o[2], oe_o[2]);
    end
    tick();
    n_checks++;
    if (oe_o[2] !== 1'b1 || busy !== 1'b1) begin
      n_errors++; $display("FAIL live_enable: oe2=%b busy=%b, expected 1/1", oe_o[2], busy);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL live_idle: busy=%b expected 0", busy); end
    $display("live_reconfig: ch2 data 83 done");
  endtask

  task automatic test_vbias();
    vbias = 1'b1;
    write_cfg(4, 8'h41); tick(); tick();
    write_cfg(5, 8'h40); tick(); tick();
    vbias = 1'b0;
    tick();
    n_checks++;
    if (oe_o[4] !== 1'b0 || fault_o[4] !== 1'b1 || oe_o[2] !== 1'b0 || fault_o[2] !== 1'b1) begin
      n_errors++; $display("FAIL vbias_drop: oe=%b fault=%b, expected ch2/ch4 oe 0 fault 1", oe_o, fault_o);
    end
    n_checks++;
    if (oe_o[5] !== 1'b1 || fault_o[5] !== 1'b0) begin
      n_errors++; $display("FAIL vbias_ds0_kept: oe5=%b fault5=%b, expected 1/0", oe_o[5], fault_o[5]);
    end
    write_cfg(3, 8'h41); tick();
    n_checks++;
    if (oe_o[3] !== 1'b0 || fault_o[3] !== 1'b1) begin
      n_errors++; $display("FAIL vbias_gate: oe3=%b fault3=%b, expected 0/1", oe_o[3], fault_o[3]);
    end
    tick();
    vbias = 1'b1;
    tick();
    n_checks++;
    if (oe_o[4] !== 1'b0 || fault_o[4] !== 1'b1) begin
      n_errors++; $display("FAIL vbias_sticky: oe4=%b fault4=%b, expected 0/1", oe_o[4], fault_o[4]);
    end
    write_cfg(4, 8'h41);
    n_checks++;
    if (fault_o[4] !== 1'b0) begin n_errors++; $display("FAIL fault_clear: fault4=%b expected 0", fault_o[4]); end
    tick(); tick();
    $display("vbias: gating and loss done");
  endtask

  task automatic test_errors();
    write_cfg(6, 8'h40);
    write_cfg(1, 8'hFF);
    n_checks++;
    if (err !== 1'b1) begin n_errors++; $display("FAIL err_busy: got %b expected 1", err); end
    tick();
    n_checks++;
    if (err !== 1'b0 || ds_o[7:4] !== 4'h0 || oe_o[1] !== 1'b0) begin
      n_errors++; $display("FAIL err_busy_after: err=%b ds1=%h oe1=%b, expected 0/0/0", err, ds_o[7:4], oe_o[1]);
    end
    write_cfg(NCH, 8'hFF);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL err_range: err=%b busy=%b, expected 1/0", err, busy);
    end
    tick();
    n_checks++;
    if (err !== 1'b0 || ds_o !== m_ds_vec() || oe_o !== m_oe) begin
      n_errors++; $display("FAIL err_range_after: err=%b ds=%h oe=%b, expected 0 ds=%h oe=%b", err, ds_o, oe_o, m_ds_vec(), m_oe);
    end
    $display("errors: busy and range rejects done");
  endtask

  task automatic test_abort();
    write_cfg(5, 8'h61);
    tick();
    rstn = 1'b0;
    tick();
    n_checks++;
    if ({ds_o, sr_o, co_o, oe_o, odp_o, odn_o, fault_o, err, busy} !== '0) begin
      n_errors++; $display("FAIL abort_reset: oe=%b ds=%h busy=%b, expected all 0", oe_o, ds_o, busy);
    end
    rstn = 1'b1;
    write_cfg(5, 8'h61);
    n_checks++;
    if (busy !== 1'b1 || oe_o[5] !== 1'b0 || ds_o[23:20] !== 4'h1 || co_o[5] !== 1'b1) begin
      n_errors++; $display("FAIL abort_cold_apply: busy=%b oe5=%b ds5=%h co5=%b, expected 1/0/1/1", busy, oe_o[5], ds_o[23:20], co_o[5]);
    end
    tick();
    n_checks++;
    if (oe_o[5] !== 1'b1) begin n_errors++; $display("FAIL abort_cold_enable: oe5=%b expected 1", oe_o[5]); end
    tick();
    $display("abort: reset during drain done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rstn  = ($urandom_range(0, 199) != 0);
      we    = ($urandom_range(0, 3) == 0);
      ch    = CHW'($urandom_range(0, 9));
      data  = 8'($urandom);
      vbias = ($urandom_range(0, 9) != 0);
      tick();
      n_checks++;
      if (do_o !== m_do) begin n_errors++; $display("FAIL rand_do cyc %0d: got %b expected %b", i, do_o, m_do); end
      n_checks++;
      if (ds_o !== m_ds_vec()) begin n_errors++; $display("FAIL rand_ds cyc %0d: got %h expected %h", i, ds_o, m_ds_vec()); end
      n_checks++;
      if ({sr_o, co_o, odp_o, odn_o} !== {m_sr, m_co, m_odp, m_odn}) begin
        n_errors++; $display("FAIL rand_cfg cyc %0d: sr/co/odp/odn got %b %b %b %b expected %b %b %b %b", i, sr_o, co_o, odp_o, odn_o, m_sr, m_co, m_odp, m_odn);
      end
      n_checks++;
      if (oe_o !== m_oe) begin n_errors++; $display("FAIL rand_oe cyc %0d: got %b expected %b", i, oe_o, m_oe); end
      n_checks++;
      if (fault_o !== m_fault) begin n_errors++; $display("FAIL rand_fault cyc %0d: got %b expected %b", i, fault_o, m_fault); end
      n_checks++;
      if (busy !== m_busy() || err !== m_err) begin
        n_errors++; $display("FAIL rand_busy_err cyc %0d: got %b/%b expected %b/%b", i, busy, err, m_busy(), m_err);
      end
    end
    $display("random: 3000 cycles done");
  endtask

  initial begin
    rstn = 1'b0; we = 1'b0; ch = '0; data = '0; din = '0; vbias = 1'b1;
    test_reset();
    test_cold_enable();
    test_live_reconfig();
    test_vbias();
    test_errors();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
